generate_idct: RTL and testbench
================================

Name: generate_idct

Overview:
- Inverse 8x8 2-D DCT. It converts a block of 12-bit signed coefficients back into 8-bit unsigned pixels.
- Counterpart to the forward DCT block. It uses the same Q10 coefficient set, the same row-then-column separable structure and the same level shift of 128 per pixel.
- Sits on the decode/reconstruction path, after dequantisation. Operation is one block per Start with a Busy/Done handshake.

Parameters:
- COEFF_W, 12, width of each signed input coefficient.
- FRAC, 10, fraction bits of the cosine constants; shift applied after each pass.
- ACC_W, 32, signed width of all internal products and sums.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request; samples dct_0..dct_7.
- dct_0..dct_7  input  96 each  row r of coefficients; element c at [c*12 +: 12], two's complement.
- pixels_0..pixels_7  output  64 each  row r of pixels; element c at [c*8 +: 8], unsigned.
- Busy  output  1  high from the cycle after Start is accepted until Done rises.
- Done  output  1  level; block result valid.

Behaviour:
- Constants (Q10): c0=502, c1=473, c2=426, c3=362, c4=284, c5=196, c6=100.
- Reset (any time, including mid-block):
  - state goes to IDLE.
  - Busy=0, Done=0.
  - All pixel outputs and internal coefficient, temp and pixel registers = 0.
- States: IDLE, ROW_EO, ROW_BF, COL_EO, COL_BF, DONE. One-hot encoding.
- IDLE or DONE with Start=1:
  - Latch all 64 sign-extended coefficients.
  - Done<=0, Busy<=1.
  - Go to ROW_EO.
  - Start in any other state is ignored; there is no queueing.
- ROW_EO, for each row r, register full-precision Q10 terms:
  - e0=c3(X0+X4), e1=c3(X0-X4), e2=c1X2+c5X6, e3=c5X2-c1X6.
  - o0=c0X1+c2X3+c4X5+c6X7.
  - o1=c2X1-c6X3-c0X5-c4X7.
  - o2=c4X1-c0X3+c6X5+c2X7.
  - o3=c6X1-c4X3+c2X5-c0X7.
- ROW_BF: write temp[r][*], each value rounded as R(v)=(v+512)>>>10 (arithmetic shift):
  - x0=R(e0+e2+o0), x7=R(e0+e2-o0).
  - x1=R(e1+e3+o1), x6=R(e1+e3-o1).
  - x2=R(e1-e3+o2), x5=R(e1-e3-o2).
  - x3=R(e0-e2+o3), x4=R(e0-e2-o3).
- COL_EO / COL_BF: same equations applied down each column of temp.
- COL_BF also forms p = result + 128 and saturates it to [0,255] before writing pixel registers.
- After COL_BF the block enters DONE: Busy<=0, Done<=1.
- Latency: Start sampled at edge N gives Done=1 and valid pixels after edge N+5.
- DONE holds its outputs until Reset or the next accepted Start.
- pixels_* outputs hold the previous block until the COL_BF of the next block; they never show partial results.
- All arithmetic is signed ACC_W; no intermediate overflow is possible for 12-bit inputs.

Decomposition:
- Shared package `dct_pkg`: the Q10 constants c0..c6, FRAC, COEFF_W, state encodings, and the pack/unpack index macros. These are shared with the forward DCT.
- One natural sub-module: `idct_1d8`, a combinational 8-point even/odd term generator plus butterfly-with-round.
  - Eight instances are reused for both row and column passes, selected by state.
  - Clamp and level shift stay in the top level.

Test Plan:
- All coefficients 0, Start -> Done 5 cycles later; every pixel = 128; Busy high for exactly 5 cycles.
- dct[0][0]=80, others 0 -> row pass gives 28, column pass gives 10; every pixel = 138.
- dct[0][0]=2047 -> every pixel = 255 (saturate high). dct[0][0]=-2048 -> every pixel = 0 (saturate low).
- Random pixel blocks: transform with a float DCT model, round to 12 bits, apply -> each pixel within ±2 of the original. Also run back-to-back blocks with Start asserted in the DONE cycle.
- Start re-pulsed during ROW_BF with different data -> ignored; result matches the first block and Done still rises at N+5.
- Reset asserted in COL_EO -> outputs 0 and Done 0 immediately (asynchronous); a following Start completes normally.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared 8x8 DCT/IDCT definitions: Q10 cosine set, widths, FSM encoding and
// pack/unpack helpers used by both transform directions.
package dct_pkg;

  localparam int unsigned COEFF_W   = 12;
  localparam int unsigned FRAC      = 10;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned NPT       = 8;
  localparam int unsigned ROW_IN_W  = NPT * COEFF_W;
  localparam int unsigned ROW_PIX_W = NPT * PIX_W;

  typedef logic signed [ACC_W-1:0] acc_t;

  // 0.5*cos(k*pi/16) in Q10 (c3 is the DC weight 0.5*cos(pi/4))
  localparam acc_t C0 = acc_t'(502);
  localparam acc_t C1 = acc_t'(473);
  localparam acc_t C2 = acc_t'(426);
  localparam acc_t C3 = acc_t'(362);
  localparam acc_t C4 = acc_t'(284);
  localparam acc_t C5 = acc_t'(196);
  localparam acc_t C6 = acc_t'(100);

  localparam acc_t RND_HALF = acc_t'(1 << (FRAC - 1));
  localparam acc_t LEVEL    = acc_t'(128);
  localparam acc_t PIX_MAX  = acc_t'(255);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    ROW_EO = 6'b000010,
    ROW_BF = 6'b000100,
    COL_EO = 6'b001000,
    COL_BF = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  function automatic int unsigned coef_lsb(input int unsigned idx);
    return idx * COEFF_W;
  endfunction

  function automatic int unsigned pix_lsb(input int unsigned idx);
    return idx * PIX_W;
  endfunction

  // Round-half-up back to integer after a Q10 pass
  function automatic acc_t round_q(input acc_t v);
    return (v + RND_HALF) >>> FRAC;
  endfunction

endpackage

// File: rtl/idct_1d8.sv
// Combinational 8-point IDCT slice: even/odd term generator and the
// butterfly-with-round that consumes previously registered terms.
module idct_1d8
  import dct_pkg::*;
(
  input  acc_t x_in  [NPT],
  input  acc_t eo_in [NPT],
  output acc_t eo_c  [NPT],
  output acc_t y_c   [NPT]
);

  acc_t e0, e1, e2, e3, o0, o1, o2, o3;

  // Terms ordered e0..e3 then o0..o3
  always_comb begin
    eo_c[0] = C3 * (x_in[0] + x_in[4]);
    eo_c[1] = C3 * (x_in[0] - x_in[4]);
    eo_c[2] = C1 * x_in[2] + C5 * x_in[6];
    eo_c[3] = C5 * x_in[2] - C1 * x_in[6];
    eo_c[4] = C0 * x_in[1] + C2 * x_in[3] + C4 * x_in[5] + C6 * x_in[7];
    eo_c[5] = C2 * x_in[1] - C6 * x_in[3] - C0 * x_in[5] - C4 * x_in[7];
    eo_c[6] = C4 * x_in[1] - C0 * x_in[3] + C6 * x_in[5] + C2 * x_in[7];
    eo_c[7] = C6 * x_in[1] - C4 * x_in[3] + C2 * x_in[5] - C0 * x_in[7];
  end

  always_comb begin
    e0 = eo_in[0];
    e1 = eo_in[1];
    e2 = eo_in[2];
    e3 = eo_in[3];
    o0 = eo_in[4];
    o1 = eo_in[5];
    o2 = eo_in[6];
    o3 = eo_in[7];
    y_c[0] = round_q(e0 + e2 + o0);
    y_c[7] = round_q(e0 + e2 - o0);
    y_c[1] = round_q(e1 + e3 + o1);
    y_c[6] = round_q(e1 + e3 - o1);
    y_c[2] = round_q(e1 - e3 + o2);
    y_c[5] = round_q(e1 - e3 - o2);
    y_c[3] = round_q(e0 - e2 + o3);
    y_c[4] = round_q(e0 - e2 - o3);
  end

endmodule

// File: rtl/generate_idct.sv
// 8x8 inverse DCT: row pass then column pass over eight shared 1-D slices,
// level shift and saturation to 8-bit pixels, Start/Busy/Done handshake.
module generate_idct
  import dct_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [ROW_IN_W-1:0]  dct_0,
  input  logic [ROW_IN_W-1:0]  dct_1,
  input  logic [ROW_IN_W-1:0]  dct_2,
  input  logic [ROW_IN_W-1:0]  dct_3,
  input  logic [ROW_IN_W-1:0]  dct_4,
  input  logic [ROW_IN_W-1:0]  dct_5,
  input  logic [ROW_IN_W-1:0]  dct_6,
  input  logic [ROW_IN_W-1:0]  dct_7,
  output logic [ROW_PIX_W-1:0] pixels_0,
  output logic [ROW_PIX_W-1:0] pixels_1,
  output logic [ROW_PIX_W-1:0] pixels_2,
  output logic [ROW_PIX_W-1:0] pixels_3,
  output logic [ROW_PIX_W-1:0] pixels_4,
  output logic [ROW_PIX_W-1:0] pixels_5,
  output logic [ROW_PIX_W-1:0] pixels_6,
  output logic [ROW_PIX_W-1:0] pixels_7,
  output logic                 Busy,
  output logic                 Done
);

  state_t               state_q, state_d;
  logic                 busy_d, done_d, accept_c, col_pass;
  logic [ROW_IN_W-1:0]  dct_row [NPT];
  logic [ROW_PIX_W-1:0] pix_q   [NPT];
  acc_t                 coef_q  [NPT][NPT];
  acc_t                 temp_q  [NPT][NPT];
  acc_t                 terms_q [NPT][NPT];
  acc_t                 lane_x  [NPT][NPT];
  acc_t                 lane_eo [NPT][NPT];
  acc_t                 lane_y  [NPT][NPT];

  assign dct_row[0] = dct_0;
  assign dct_row[1] = dct_1;
  assign dct_row[2] = dct_2;
  assign dct_row[3] = dct_3;
  assign dct_row[4] = dct_4;
  assign dct_row[5] = dct_5;
  assign dct_row[6] = dct_6;
  assign dct_row[7] = dct_7;

  assign pixels_0 = pix_q[0];
  assign pixels_1 = pix_q[1];
  assign pixels_2 = pix_q[2];
  assign pixels_3 = pix_q[3];
  assign pixels_4 = pix_q[4];
  assign pixels_5 = pix_q[5];
  assign pixels_6 = pix_q[6];
  assign pixels_7 = pix_q[7];

  function automatic logic [PIX_W-1:0] sat_pix(input acc_t v);
    acc_t p;
    p = v + LEVEL;
    if (p < 0)            return '0;
    else if (p > PIX_MAX) return '1;
    else                  return p[PIX_W-1:0];
  endfunction

  // Lane i is row i in the row pass and column i in the column pass
  assign col_pass = (state_q == COL_EO) || (state_q == COL_BF);

  always_comb begin
    for (int i = 0; i < NPT; i++) begin
      for (int k = 0; k < NPT; k++) begin
        lane_x[i][k] = col_pass ? temp_q[k][i] : coef_q[i][k];
      end
    end
  end

  for (genvar g = 0; g < NPT; g++) begin : g_lane
    idct_1d8 u_1d (
      .x_in  (lane_x[g]),
      .eo_in (terms_q[g]),
      .eo_c  (lane_eo[g]),
      .y_c   (lane_y[g])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

  // DONE is entered with Busy still high; Done rises one cycle later,
  // and only then is a new Start accepted
  always_comb begin
    state_d  = state_q;
    busy_d   = Busy;
    done_d   = Done;
    accept_c = 1'b0;
    case (state_q)
      IDLE:   accept_c = Start;
      ROW_EO: state_d = ROW_BF;
      ROW_BF: state_d = COL_EO;
      COL_EO: state_d = COL_BF;
      COL_BF: state_d = DONE;
      DONE: begin
        if (!Done) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          accept_c = Start;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      state_d = ROW_EO;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NPT; i++) begin
        pix_q[i] <= '0;
        for (int k = 0; k < NPT; k++) begin
          coef_q[i][k]  <= '0;
          temp_q[i][k]  <= '0;
          terms_q[i][k] <= '0;
        end
      end
    end else begin
      if (accept_c) begin
        for (int r = 0; r < NPT; r++) begin
          for (int c = 0; c < NPT; c++) begin
            coef_q[r][c] <= acc_t'($signed(dct_row[r][coef_lsb(c) +: COEFF_W]));
          end
        end
      end
      for (int i = 0; i < NPT; i++) begin
        for (int k = 0; k < NPT; k++) begin
          case (state_q)
            ROW_EO, COL_EO: terms_q[i][k] <= lane_eo[i][k];
            ROW_BF:         temp_q[i][k]  <= lane_y[i][k];
            COL_BF:         pix_q[k][pix_lsb(i) +: PIX_W] <= sat_pix(lane_y[i][k]);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_generate_idct.sv
// Directed bench for generate_idct: handshake timing, DC/AC vectors,
// saturation, float-DCT round trips, ignored restart and async reset.
module tb_generate_idct;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [95:0] dct_v [8];
  logic [63:0] px    [8];
  logic        Busy, Done;
  int          total = 0;
  int          bad   = 0;
  int          orig  [8][8];

  always #5 Clk = ~Clk;

  generate_idct dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .dct_0(dct_v[0]), .dct_1(dct_v[1]), .dct_2(dct_v[2]), .dct_3(dct_v[3]),
    .dct_4(dct_v[4]), .dct_5(dct_v[5]), .dct_6(dct_v[6]), .dct_7(dct_v[7]),
    .pixels_0(px[0]), .pixels_1(px[1]), .pixels_2(px[2]), .pixels_3(px[3]),
    .pixels_4(px[4]), .pixels_5(px[5]), .pixels_6(px[6]), .pixels_7(px[7]),
    .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rows(input string tag, input logic [63:0] exp);
    for (int r = 0; r < 8; r++) chk($sformatf("%s_row%0d", tag, r), px[r], exp);
  endtask

  task automatic clear_coefs();
    for (int r = 0; r < 8; r++) dct_v[r] = '0;
  endtask

  task automatic set_coef(input int r, input int c, input int v);
    dct_v[r][c*12 +: 12] = 12'(v);
  endtask

  // Called at a negedge; pulses Start across the next posedge (edge N)
  task automatic run_block(input string tag);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), {62'b0, Busy, Done}, 64'd2);
      @(negedge Clk);
    end
    chk($sformatf("%s_done", tag), {62'b0, Busy, Done}, 64'd1);
  endtask

  // Random pixel block -> orthonormal float DCT -> 12-bit coefficients
  task automatic load_random();
    real pi, s, f, cu, cv;
    int  iv;
    pi = 3.14159265358979;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) orig[r][c] = int'($urandom_range(16, 239));
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        s = 0.0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            s = s + (real'(orig[r][c]) - 128.0)
                  * $cos((2.0*r + 1.0) * u * pi / 16.0)
                  * $cos((2.0*c + 1.0) * v * pi / 16.0);
        cu = (u == 0) ? 0.70710678 : 1.0;
        cv = (v == 0) ? 0.70710678 : 1.0;
        f  = 0.25 * cu * cv * s;
        iv = $rtoi((f >= 0.0) ? f + 0.5 : f - 0.5);
        if (iv > 2047)  iv = 2047;
        if (iv < -2048) iv = -2048;
        set_coef(u, v, iv);
      end
    end
  endtask

  task automatic chk_near(input string tag);
    int obs, d;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        obs = int'(px[r][c*8 +: 8]);
        d   = obs - orig[r][c];
        total++;
        assert (d <= 2 && d >= -2) else begin
          bad++;
          $error("FAIL %s[%0d][%0d]: observed=%0d expected=%0d+-2", tag, r, c, obs, orig[r][c]);
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    clear_coefs();
    repeat (2) @(negedge Clk);
    chk("reset_flags", {62'b0, Busy, Done}, 64'd0);
    chk_rows("reset_pix", 64'h0);
    Reset = 1'b0;
    @(negedge Clk);

    // All-zero block -> mid grey
    run_block("zero");
    chk_rows("zero_pix", 64'h8080808080808080);

    // DC 80: 80*362 -> 28 after rows, 10 after columns
    clear_coefs();
    set_coef(0, 0, 80);
    run_block("dc80");
    chk_rows("dc80_pix", 64'h8A8A8A8A8A8A8A8A);

    // X[0][4]=80: row 0 = +-28 pattern, columns +-10 -> 138/118
    clear_coefs();
    set_coef(0, 4, 80);
    run_block("ac04");
    chk_rows("ac04_pix", 64'h8A76768A8A76768A);

    clear_coefs();
    set_coef(0, 0, 2047);
    run_block("sat_hi");
    chk_rows("sat_hi_pix", 64'hFFFFFFFFFFFFFFFF);

    clear_coefs();
    set_coef(0, 0, -2048);
    run_block("sat_lo");
    chk_rows("sat_lo_pix", 64'h0);

    // Round trips, second Start issued in the Done cycle
    load_random();
    run_block("rnd_a");
    chk_near("rnd_a_pix");
    load_random();
    run_block("rnd_b");
    chk_near("rnd_b_pix");

    // Start re-pulsed during ROW_BF with other data is ignored
    clear_coefs();
    set_coef(0, 0, 80);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    clear_coefs();
    set_coef(0, 0, 2047);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("restart_busy", {62'b0, Busy, Done}, 64'd2);
    @(negedge Clk);
    @(negedge Clk);
    chk("restart_n4", {62'b0, Busy, Done}, 64'd2);
    @(negedge Clk);
    chk("restart_done", {62'b0, Busy, Done}, 64'd1);
    chk_rows("restart_pix", 64'h8A8A8A8A8A8A8A8A);

    // Reset in COL_EO clears outputs without a clock edge
    clear_coefs();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midrst_flags", {62'b0, Busy, Done}, 64'd0);
    chk_rows("midrst_pix", 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    set_coef(0, 0, 80);
    run_block("post_rst");
    chk_rows("post_rst_pix", 64'h8A8A8A8A8A8A8A8A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
